state_uart_tx: RTL and testbench
================================

STATE_UART_TX -- requirements
Module: state_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per UART bit; legal range 4..65535.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  one clock; reset is synchronous and active-low.
REQ-004 state  input  2  FSM state code: 00 normal, 01 warning, 10 alert, 11 undefined.
REQ-005 uart_tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-006 tx_busy  output  1  high while any frame pair (status char plus LF) is being shifted.
REQ-007 ack  output  1  one-cycle pulse after an 'A' report has fully left the line; drives the FSM ack input.
REQ-008 overrun  output  1  sticky flag: a pending report was overwritten before transmission.

Function
REQ-009 Change detect: last_state register holds the previously sampled state; on any edge where state != last_state, last_state <= state, pend_valid <= 1, pend_char <= map(state).
REQ-010 Map: 00 -> 0x30 '0', 01 -> 0x31 '1', 10 -> 0x41 'A', 11 -> 0x3F '?'.
REQ-011 Pending buffer is one entry deep; a new change while pend_valid=1 and not consumed on the same edge overwrites pend_char (latest wins) and sets overrun.
REQ-012 Simultaneous change and consumption on one edge: consumed char is loaded into the shifter, the new char becomes pending, pend_valid stays 1, overrun not set.
REQ-013 TX FSM states: IDLE, START, DATA, STOP; plus a 1-bit byte_sel (0 = status char, 1 = LF 0x0A).
REQ-014 IDLE with pend_valid=1: on that edge, shifter <= pend_char, pend_valid <= 0, byte_sel <= 0, uart_tx <= 0, go START; tx_busy <= 1.
REQ-015 Each bit (start, 8 data, stop) lasts exactly CLKS_PER_BIT cycles, counted by a bit-timer that reloads at every bit boundary.
REQ-016 START -> DATA after one bit time; DATA shifts out bit[0] first, 8 bits counted by a 3-bit index; DATA -> STOP after bit 7; STOP drives uart_tx=1.
REQ-017 STOP end with byte_sel=0: shifter <= 0x0A, byte_sel <= 1, uart_tx <= 0, go START (no idle gap between bytes).
REQ-018 STOP end with byte_sel=1: go IDLE, tx_busy <= 0; if the transmitted status char was 0x41, ack = 1 for that cycle only.
REQ-019 Latency: uart_tx start bit of the status char goes low 2 clk edges after the state change is presented (edge 1 registers pend, edge 2 starts TX) when idle.
REQ-020 A full report occupies exactly 20*CLKS_PER_BIT cycles; tx_busy is high for exactly that many cycles.
REQ-021 Back-to-back: if pend_valid=1 when returning to IDLE, the next report starts on the following edge (one idle-high cycle between reports).
REQ-022 state input is used as presented; a change back to the last reported value before consumption still overwrites pending (no suppression).

Reset
REQ-023 While reset=0 at a rising edge: uart_tx=1, tx_busy=0, ack=0, overrun=0, pend_valid=0, last_state=00, TX FSM=IDLE, counters=0.
REQ-024 Reset mid-frame aborts transmission immediately; line returns high on the reset edge; no ack is emitted for the aborted report.
REQ-025 No report is sent on reset release; the first report requires a change from 00.

Verification (CLKS_PER_BIT=16)
REQ-026 state 00->01 when idle -> uart_tx low 2 edges later; data bits 1,0,0,0,1,1,0,0; stop; then 0x0A bits 0,1,0,1,0,0,0,0; tx_busy high exactly 320 cycles; ack stays 0.
REQ-027 state 00->10 -> 'A' then LF transmitted; ack pulses exactly 1 cycle on the edge tx_busy falls.
REQ-028 state 00->01->10 in consecutive cycles while idle -> '1' report, then '0x41' report after one idle-high cycle; overrun stays 0.
REQ-029 During an active report, change state 3 times (01,10,11) -> only '?' sent next; overrun=1 and remains 1 until reset.
REQ-030 Reset asserted at cycle 100 of a report -> uart_tx=1, tx_busy=0 on that edge; no ack; no report after release until state changes from 00.

Source files
------------

// File: rtl/state_uart_tx.sv
// Reports FSM state changes over an 8N1 UART line as a status character followed by LF.
// A one-deep pending buffer holds the latest unreported change; 'A' reports raise ack when done.
module state_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] state,
   output logic       uart_tx,
   output logic       tx_busy,
   output logic       ack,
   output logic       overrun
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [7:0]  LF_CHAR  = 8'h0A;
   localparam logic [7:0]  A_CHAR   = 8'h41;

   tx_state_t   tx_state, tx_state_nxt;
   logic        byte_sel, byte_sel_nxt;
   logic [7:0]  shifter, shifter_nxt;
   logic [2:0]  bit_idx, bit_idx_nxt;
   logic [15:0] bit_timer, bit_timer_nxt;
   logic [1:0]  last_state, last_state_nxt;
   logic        pend_valid, pend_valid_nxt;
   logic [7:0]  pend_char, pend_char_nxt;
   logic        sent_a, sent_a_nxt;
   logic        uart_tx_nxt, tx_busy_nxt, ack_nxt, overrun_nxt;
   logic        consume, bit_done;

   function automatic logic [7:0] map_char(input logic [1:0] s);
      case (s)
         2'b00:   return 8'h30;
         2'b01:   return 8'h31;
         2'b10:   return 8'h41;
         default: return 8'h3F;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_state   <= IDLE;
         byte_sel   <= 1'b0;
         shifter    <= '0;
         bit_idx    <= '0;
         bit_timer  <= '0;
         last_state <= 2'b00;
         pend_valid <= 1'b0;
         pend_char  <= '0;
         sent_a     <= 1'b0;
         uart_tx    <= 1'b1;
         tx_busy    <= 1'b0;
         ack        <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         tx_state   <= tx_state_nxt;
         byte_sel   <= byte_sel_nxt;
         shifter    <= shifter_nxt;
         bit_idx    <= bit_idx_nxt;
         bit_timer  <= bit_timer_nxt;
         last_state <= last_state_nxt;
         pend_valid <= pend_valid_nxt;
         pend_char  <= pend_char_nxt;
         sent_a     <= sent_a_nxt;
         uart_tx    <= uart_tx_nxt;
         tx_busy    <= tx_busy_nxt;
         ack        <= ack_nxt;
         overrun    <= overrun_nxt;
      end
   end

   always_comb begin
      tx_state_nxt   = tx_state;
      byte_sel_nxt   = byte_sel;
      shifter_nxt    = shifter;
      bit_idx_nxt    = bit_idx;
      last_state_nxt = last_state;
      pend_valid_nxt = pend_valid;
      pend_char_nxt  = pend_char;
      sent_a_nxt     = sent_a;
      uart_tx_nxt    = uart_tx;
      tx_busy_nxt    = tx_busy;
      ack_nxt        = 1'b0;
      overrun_nxt    = overrun;
      consume        = 1'b0;
      bit_done       = (bit_timer == BIT_LAST);
      bit_timer_nxt  = bit_done ? 16'd0 : bit_timer + 16'd1;

      case (tx_state)
         IDLE: begin
            bit_timer_nxt = '0;
            if (pend_valid) begin
               consume      = 1'b1;
               shifter_nxt  = pend_char;
               sent_a_nxt   = (pend_char == A_CHAR);
               byte_sel_nxt = 1'b0;
               uart_tx_nxt  = 1'b0;
               tx_busy_nxt  = 1'b1;
               tx_state_nxt = START;
            end
         end
         START: begin
            if (bit_done) begin
               uart_tx_nxt  = shifter[0];
               bit_idx_nxt  = '0;
               tx_state_nxt = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx == 3'd7) begin
                  uart_tx_nxt  = 1'b1;
                  tx_state_nxt = STOP;
               end else begin
                  shifter_nxt = {1'b0, shifter[7:1]};
                  uart_tx_nxt = shifter[1];
                  bit_idx_nxt = bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            // The LF follows the status char with no idle gap; only the pair's end frees the line.
            if (bit_done) begin
               if (!byte_sel) begin
                  shifter_nxt  = LF_CHAR;
                  byte_sel_nxt = 1'b1;
                  uart_tx_nxt  = 1'b0;
                  tx_state_nxt = START;
               end else begin
                  tx_busy_nxt  = 1'b0;
                  ack_nxt      = sent_a;
                  tx_state_nxt = IDLE;
               end
            end
         end
         default: tx_state_nxt = IDLE;
      endcase

      // A change arriving on the consume edge refills the buffer without counting as an overrun.
      if (state != last_state) begin
         last_state_nxt = state;
         pend_char_nxt  = map_char(state);
         pend_valid_nxt = 1'b1;
         if (pend_valid && !consume)
            overrun_nxt = 1'b1;
      end else if (consume) begin
         pend_valid_nxt = 1'b0;
      end
   end

endmodule

// File: tb/tb_state_uart_tx.sv
// Directed bench for state_uart_tx at 16 clocks per bit: latency, framing, ack,
// back-to-back reports, overrun and mid-frame reset.
module tb_state_uart_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] state = 2'b00;
   logic       uart_tx, tx_busy, ack, overrun;

   int total = 0;
   int bad = 0;

   state_uart_tx #(.CLKS_PER_BIT(16)) dut (
      .clk     (clk),
      .reset   (reset),
      .state   (state),
      .uart_tx (uart_tx),
      .tx_busy (tx_busy),
      .ack     (ack),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   // Line bits in time order (bit 0 first): start, char LSB..MSB, stop, start, LF, stop.
   function automatic logic [19:0] frame_of(input logic [7:0] ch);
      return {1'b1, 8'h0A, 1'b0, 1'b1, ch, 1'b0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      state = 2'b00;
      repeat (3) step();
      reset = 1'b1;
      step();
   endtask

   // Records one report starting at cycle c0 (cycle 0 is the edge the start bit fell);
   // returns positioned one cycle after tx_busy falls.
   task automatic capture(input int c0, output logic [19:0] bits, output int busy_cycles,
                          output int ack_cycles, output int ack_at);
      int c;
      bits = '1;
      busy_cycles = c0;
      ack_cycles = 0;
      ack_at = -1;
      c = c0;
      while (c < 400) begin
         if (ack) begin
            ack_cycles++;
            ack_at = c;
         end
         if (!tx_busy) break;
         busy_cycles++;
         if ((c % 16) == 8 && (c / 16) < 20) bits[c / 16] = uart_tx;
         step();
         c++;
      end
      step();
      if (ack) ack_cycles++;
   endtask

   // Presents a new state and checks the two-edge latency to the start bit.
   task automatic start_change(input logic [1:0] s, input string tag);
      state = s;
      step();
      total++;
      if (uart_tx !== 1'b1) begin
         bad++;
         $display("[TB] FAIL %s_edge1_line: got %b expected 1", tag, uart_tx);
      end
      step();
      total++;
      if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL %s_start_bit: got tx=%b busy=%b expected tx=0 busy=1", tag, uart_tx, tx_busy);
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || ack !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got tx=%b busy=%b ack=%b ovr=%b expected 1 0 0 0",
                  uart_tx, tx_busy, ack, overrun);
      end
      repeat (10) step();
      total++;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_no_report: got tx=%b busy=%b expected 1 0", uart_tx, tx_busy);
      end
   endtask

   task automatic test_warning();
      logic [19:0] bits;
      int busy_n, ack_n, ack_at;
      do_reset();
      start_change(2'b01, "warn");
      capture(0, bits, busy_n, ack_n, ack_at);
      total++;
      if (bits !== frame_of(8'h31)) begin
         bad++;
         $display("[TB] FAIL warn_bits: got %b expected %b", bits, frame_of(8'h31));
      end
      total++;
      if (busy_n !== 320) begin
         bad++;
         $display("[TB] FAIL warn_busy_len: got %0d expected 320", busy_n);
      end
      total++;
      if (ack_n !== 0) begin
         bad++;
         $display("[TB] FAIL warn_no_ack: got %0d pulses expected 0", ack_n);
      end
   endtask

   task automatic test_alert();
      logic [19:0] bits;
      int busy_n, ack_n, ack_at;
      do_reset();
      start_change(2'b10, "alert");
      capture(0, bits, busy_n, ack_n, ack_at);
      total++;
      if (bits !== frame_of(8'h41)) begin
         bad++;
         $display("[TB] FAIL alert_bits: got %b expected %b", bits, frame_of(8'h41));
      end
      total++;
      if (ack_n !== 1 || ack_at !== 320) begin
         bad++;
         $display("[TB] FAIL alert_ack: got %0d pulses at %0d expected 1 at 320", ack_n, ack_at);
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] bits;
      int busy_n, ack_n, ack_at;
      do_reset();
      state = 2'b01;
      step();
      state = 2'b10;
      step();
      total++;
      if (uart_tx !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_start_bit: got %b expected 0", uart_tx);
      end
      capture(0, bits, busy_n, ack_n, ack_at);
      total++;
      if (bits !== frame_of(8'h31) || ack_n !== 0) begin
         bad++;
         $display("[TB] FAIL b2b_first: got %b ack=%0d expected %b ack=0", bits, ack_n, frame_of(8'h31));
      end
      total++;
      if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL b2b_gap: got tx=%b busy=%b expected tx=0 busy=1", uart_tx, tx_busy);
      end
      capture(0, bits, busy_n, ack_n, ack_at);
      total++;
      if (bits !== frame_of(8'h41) || ack_n !== 1) begin
         bad++;
         $display("[TB] FAIL b2b_second: got %b ack=%0d expected %b ack=1", bits, ack_n, frame_of(8'h41));
      end
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun);
      end
   endtask

   task automatic test_overrun();
      logic [19:0] bits;
      int busy_n, ack_n, ack_at;
      do_reset();
      start_change(2'b10, "ovr");
      state = 2'b01;
      step();
      state = 2'b10;
      step();
      state = 2'b11;
      step();
      step();
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ovr_set: got %b expected 1", overrun);
      end
      capture(4, bits, busy_n, ack_n, ack_at);
      total++;
      if (bits !== frame_of(8'h41) || busy_n !== 320) begin
         bad++;
         $display("[TB] FAIL ovr_first: got %b busy=%0d expected %b busy=320", bits, busy_n, frame_of(8'h41));
      end
      capture(0, bits, busy_n, ack_n, ack_at);
      total++;
      if (bits !== frame_of(8'h3F) || ack_n !== 0) begin
         bad++;
         $display("[TB] FAIL ovr_latest: got %b ack=%0d expected %b ack=0", bits, ack_n, frame_of(8'h3F));
      end
      repeat (20) step();
      total++;
      if (tx_busy !== 1'b0 || overrun !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ovr_sticky: got busy=%b ovr=%b expected busy=0 ovr=1", tx_busy, overrun);
      end
   endtask

   task automatic test_reset_midframe();
      logic [19:0] bits;
      int busy_n, ack_n, ack_at;
      bit quiet;
      do_reset();
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midrst_ovr_clear: got %b expected 0", overrun);
      end
      start_change(2'b10, "midrst");
      repeat (99) step();
      total++;
      if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midrst_mid_bit: got tx=%b busy=%b expected tx=0 busy=1", uart_tx, tx_busy);
      end
      reset = 1'b0;
      state = 2'b00;
      step();
      total++;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || ack !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midrst_abort: got tx=%b busy=%b ack=%b expected 1 0 0", uart_tx, tx_busy, ack);
      end
      step();
      reset = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || ack !== 1'b0) quiet = 1'b0;
      end
      total++;
      if (quiet !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midrst_quiet: got activity=%b expected none", !quiet);
      end
      start_change(2'b01, "midrst_next");
      capture(0, bits, busy_n, ack_n, ack_at);
      total++;
      if (bits !== frame_of(8'h31) || ack_n !== 0) begin
         bad++;
         $display("[TB] FAIL midrst_next_frame: got %b ack=%0d expected %b ack=0", bits, ack_n, frame_of(8'h31));
      end
   endtask

   initial begin
      test_reset();
      test_warning();
      test_alert();
      test_back_to_back();
      test_overrun();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
